// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared sequencer state type and load/store opcode decode
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALTED
  } seq_state_t;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LWL = 6'h22;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LWR = 6'h26;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SWL = 6'h2A;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SWR = 6'h2E;

  function automatic logic is_load(input logic [5:0] opcode);
    case (opcode)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR: is_load = 1'b1;
      default: is_load = 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [5:0] opcode);
    case (opcode)
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: is_store = 1'b1;
      default: is_store = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - sequencer connection to decoder, PC and memory bus
interface cpu_sequencer_if;
  logic        waitrequest;
  logic [5:0]  opcode;
  logic [31:0] pc_address;
  logic        mem_read;
  logic        mem_write;
  logic        addr_sel;
  logic        ir_load;
  logic        cycle_1;
  logic        cycle_2;
  logic        active;
  logic        fault;

  modport master (
    input  waitrequest, opcode, pc_address,
    output mem_read, mem_write, addr_sel, ir_load, cycle_1, cycle_2, active, fault
  );

  modport slave (
    output waitrequest, opcode, pc_address,
    input  mem_read, mem_write, addr_sel, ir_load, cycle_1, cycle_2, active, fault
  );
endinterface

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - counts stalled bus cycles and flags a timeout
module bus_wait_timer #(
  parameter int MAX_WAIT = 255,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  input  logic wait_i,
  input  logic clear_i,
  output logic timeout_o
);

  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  // Any state change or completed access restarts the count for the next access.
  always_comb begin
    wait_cnt_d = '0;
    if (req_i && wait_i && !clear_i) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign timeout_o = req_i && wait_i && (wait_cnt_q == WAIT_W'(MAX_WAIT));

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/execute/memory control FSM
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR = 32'h0000_0000,
  parameter int          MAX_WAIT  = 255,
  parameter int          WAIT_W    = 8
) (
  input  logic            clk,
  input  logic            reset,
  cpu_sequencer_if.master bus
);

  seq_state_t state_q;
  seq_state_t state_d;
  logic       fault_q;

  logic is_ld;
  logic is_st;
  logic req;
  logic timeout;
  logic state_change;

  logic rd;
  logic wr;
  logic addr_sel;
  logic ir_load;
  logic cyc1;
  logic cyc2;
  logic active;

  assign is_ld = is_load(bus.opcode);
  assign is_st = is_store(bus.opcode);

  // Kept separate from the FSM block so the timeout path has no false comb loop.
  assign req = ((state_q == S_FETCH) && (bus.pc_address != HALT_ADDR)) ||
               ((state_q == S_MEM) && (is_ld || is_st));

  assign state_change = (state_d != state_q);

  bus_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req),
    .wait_i    (bus.waitrequest),
    .clear_i   (state_change),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (timeout) begin
        fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rd       = 1'b0;
    wr       = 1'b0;
    addr_sel = 1'b0;
    ir_load  = 1'b0;
    cyc1     = 1'b0;
    cyc2     = 1'b0;
    active   = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        active = 1'b1;
        cyc1   = 1'b1;
        if (bus.pc_address == HALT_ADDR) begin
          state_d = S_HALTED;
        end else begin
          rd = 1'b1;
          if (!bus.waitrequest) begin
            ir_load = 1'b1;
            state_d = S_EXEC;
          end else if (timeout) begin
            state_d = S_HALTED;
          end
        end
      end
      S_EXEC: begin
        active = 1'b1;
        if (is_ld || is_st) begin
          cyc1    = 1'b1;
          state_d = S_MEM;
        end else begin
          cyc2    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        active   = 1'b1;
        addr_sel = 1'b1;
        rd       = is_ld;
        wr       = is_st && !is_ld;
        if (bus.waitrequest) begin
          cyc1 = 1'b1;
          if (timeout) begin
            state_d = S_HALTED;
          end
        end else begin
          cyc2    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_HALTED;
      end
    endcase
  end

  assign bus.mem_read  = rd;
  assign bus.mem_write = wr;
  assign bus.addr_sel  = addr_sel;
  assign bus.ir_load   = ir_load;
  assign bus.cycle_1   = cyc1;
  assign bus.cycle_2   = cyc2;
  assign bus.active    = active;
  assign bus.fault     = fault_q;

endmodule
